// File: rtl/execute_stage.sv
// RV32I execute stage plus EX/MEM register: operand forwarding, ALU, branch/jump resolution.
// Optional macro RV32M_MUL_EN adds the MUL operation (ALU code 1010).
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [2:0]      funct3M,
    output logic [4:0]      RDM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
`ifdef RV32M_MUL_EN
    localparam logic [3:0] ALU_MUL  = 4'b1010;
`endif

    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] FwdBE;
    logic [XLEN-1:0] SrcBE;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] jalrSum;
    logic [4:0]      shamt;
    logic            branchCond;

    // Select 11 is reserved and falls back to the register file value
    always_comb begin
        SrcAE = RD1E;
        case (ForwardAE)
            2'b01:   SrcAE = ResultW;
            2'b10:   SrcAE = ALUResultM;
            default: SrcAE = RD1E;
        endcase
    end

    always_comb begin
        FwdBE = RD2E;
        case (ForwardBE)
            2'b01:   FwdBE = ResultW;
            2'b10:   FwdBE = ALUResultM;
            default: FwdBE = RD2E;
        endcase
    end

    assign SrcBE = ALUSrcE ? ImmExtE : FwdBE;
    assign shamt = SrcBE[4:0];

    always_comb begin
        aluResult = '0;
        case (ALUControlE)
            ALU_ADD:  aluResult = SrcAE + SrcBE;
            ALU_SUB:  aluResult = SrcAE - SrcBE;
            ALU_AND:  aluResult = SrcAE & SrcBE;
            ALU_OR:   aluResult = SrcAE | SrcBE;
            ALU_XOR:  aluResult = SrcAE ^ SrcBE;
            ALU_SLT:  aluResult = {{(XLEN-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
            ALU_SLTU: aluResult = {{(XLEN-1){1'b0}}, (SrcAE < SrcBE)};
            ALU_SLL:  aluResult = SrcAE << shamt;
            ALU_SRL:  aluResult = SrcAE >> shamt;
            ALU_SRA:  aluResult = $unsigned($signed(SrcAE) >>> shamt);
`ifdef RV32M_MUL_EN
            ALU_MUL:  aluResult = SrcAE * SrcBE;
`endif
            default:  aluResult = '0;
        endcase
    end

    // Branches compare the forwarded rs2 value, never the immediate
    always_comb begin
        branchCond = 1'b0;
        case (funct3E)
            3'b000:  branchCond = (SrcAE == FwdBE);
            3'b001:  branchCond = (SrcAE != FwdBE);
            3'b100:  branchCond = ($signed(SrcAE) < $signed(FwdBE));
            3'b101:  branchCond = !($signed(SrcAE) < $signed(FwdBE));
            3'b110:  branchCond = (SrcAE < FwdBE);
            3'b111:  branchCond = !(SrcAE < FwdBE);
            default: branchCond = 1'b0;
        endcase
    end

    assign jalrSum   = SrcAE + ImmExtE;
    assign PCSrcE    = JumpE | (BranchE & branchCond);
    assign PCTargetE = JalrE ? {jalrSum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            funct3M    <= '0;
            RDM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            funct3M    <= funct3E;
            RDM        <= RdE;
            ALUResultM <= aluResult;
            WriteDataM <= FwdBE;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule
